// File: rtl/note_tone_generator_pkg.sv
// Shared definitions for the note tone generator: FSM states, note word field layout,
// the centi-Hz frequency table and the half-period helper.
package note_tone_generator_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2
    } state_e;

    localparam int unsigned NOTE_LSB  = 2;
    localparam int unsigned NOTE_MSB  = 8;
    localparam int unsigned NUM_NOTES = 7;

    localparam logic [1:0] OCT_MID  = 2'b00;
    localparam logic [1:0] OCT_HIGH = 2'b01;
    localparam logic [1:0] OCT_LOW  = 2'b10;

    // do, re, mi, fa, so, la, si of the middle octave, in centi-Hz
    localparam int unsigned FREQ_CHZ [NUM_NOTES] = '{
        26163, 29366, 32963, 34923, 39200, 44000, 49388
    };

    function automatic logic note_is_rest(input logic [9:0] word);
        return ($countones(word[NOTE_MSB:NOTE_LSB]) != 1);
    endfunction

    // Half period in clock cycles; 64-bit math since CLK_FREQ*50 overflows 32 bits.
    function automatic longint unsigned half_period_mid(input int unsigned clk_freq,
                                                        input int unsigned idx);
        longint unsigned num;
        longint unsigned den;
        num = clk_freq;
        den = FREQ_CHZ[idx];
        return (num * 64'd50) / den;
    endfunction

endpackage

// File: rtl/note_period_lut.sv
// Combinational decode of a note word into rest flag, note index (1..7) and the
// octave-adjusted half-period count.
module note_period_lut
    import note_tone_generator_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned CNT_WIDTH = 21
) (
    input  logic [9:0]           word_i,
    output logic                 is_rest_o,
    output logic [2:0]           index_o,
    output logic [CNT_WIDTH-1:0] half_period_o
);

    localparam logic [CNT_WIDTH-1:0] HALF_MID [NUM_NOTES] = '{
        CNT_WIDTH'(half_period_mid(CLK_FREQ, 0)),
        CNT_WIDTH'(half_period_mid(CLK_FREQ, 1)),
        CNT_WIDTH'(half_period_mid(CLK_FREQ, 2)),
        CNT_WIDTH'(half_period_mid(CLK_FREQ, 3)),
        CNT_WIDTH'(half_period_mid(CLK_FREQ, 4)),
        CNT_WIDTH'(half_period_mid(CLK_FREQ, 5)),
        CNT_WIDTH'(half_period_mid(CLK_FREQ, 6))
    };

    logic                 unused_reserved;
    logic [CNT_WIDTH-1:0] mid;
    logic [2:0]           idx;

    assign unused_reserved = word_i[9];

    always_comb begin
        mid       = '0;
        idx       = '0;
        is_rest_o = note_is_rest(word_i);
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (word_i[NOTE_LSB + i]) begin
                mid = HALF_MID[i];
                idx = 3'(i + 1);
            end
        end
        if (is_rest_o) begin
            mid = '0;
            idx = '0;
        end
        index_o = idx;
        case (word_i[1:0])
            OCT_HIGH: half_period_o = mid >> 1;
            OCT_LOW:  half_period_o = mid << 1;
            default:  half_period_o = mid;
        endcase
    end

endmodule

// File: rtl/note_tone_generator.sv
// Square-wave tone generator: latches a one-hot note word, loads its half period and
// toggles audio_pwm at that rate; rests, mute and loss of valid silence the output.
module note_tone_generator
    import note_tone_generator_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned CNT_WIDTH = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       note_valid,
    input  logic [9:0] note_data,
    input  logic       mute,
    output logic       audio_pwm,
    output logic       audio_sd,
    output logic       playing,
    output logic [2:0] cur_note
);

    state_e               state_q, state_d;
    logic [9:0]           word_q, word_d;
    logic [CNT_WIDTH-1:0] half_q, half_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pwm_q, pwm_d;

    logic                 unused_reserved;
    logic [9:0]           eff_word;
    logic                 eff_rest;
    logic                 lut_rest;
    logic [2:0]           lut_index;
    logic [CNT_WIDTH-1:0] lut_half;

    assign unused_reserved = note_data[9];

    // Bit 9 is dropped here so the latched word and comparisons never see it.
    assign eff_word = (note_valid && !mute) ? {1'b0, note_data[8:0]} : '0;
    assign eff_rest = note_is_rest(eff_word);

    note_period_lut #(
        .CLK_FREQ  (CLK_FREQ),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_lut (
        .word_i        (word_q),
        .is_rest_o     (lut_rest),
        .index_o       (lut_index),
        .half_period_o (lut_half)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            half_q  <= '0;
            cnt_q   <= '0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        half_d  = half_q;
        cnt_d   = cnt_q;
        pwm_d   = pwm_q;
        unique case (state_q)
            S_IDLE: begin
                pwm_d = 1'b0;
                cnt_d = '0;
                if (!eff_rest) begin
                    word_d  = eff_word;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                half_d  = lut_half;
                cnt_d   = '0;
                pwm_d   = 1'b0;
                state_d = lut_rest ? S_IDLE : S_PLAY;
            end
            S_PLAY: begin
                if (eff_word != word_q) begin
                    pwm_d = 1'b0;
                    cnt_d = '0;
                    if (eff_rest) begin
                        word_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        word_d  = eff_word;
                        state_d = S_LOAD;
                    end
                end else if (cnt_q == half_q - CNT_WIDTH'(1)) begin
                    pwm_d = !pwm_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign audio_pwm = pwm_q;
    assign audio_sd  = (state_q == S_PLAY);
    assign playing   = (state_q == S_PLAY);
    assign cur_note  = (state_q == S_PLAY) ? lut_index : 3'd0;

endmodule

// File: tb/tb_note_tone_generator.sv
// Directed bench for note_tone_generator at CLK_FREQ=1 MHz: vector table plus
// hand-written sequences for reset, rests, note changes, mute and bit-9 masking.
module tb_note_tone_generator;

    logic       clk;
    logic       rst_n;
    logic       note_valid;
    logic [9:0] note_data;
    logic       mute;
    logic       audio_pwm;
    logic       audio_sd;
    logic       playing;
    logic [2:0] cur_note;

    int total;
    int bad;

    note_tone_generator #(
        .CLK_FREQ  (1000000),
        .CNT_WIDTH (21)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .note_valid (note_valid),
        .note_data  (note_data),
        .mute       (mute),
        .audio_pwm  (audio_pwm),
        .audio_sd   (audio_sd),
        .playing    (playing),
        .cur_note   (cur_note)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] data;
        logic       valid;
        logic       mute;
        int         half;
        int         idx;
        logic       play;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        note_valid = 1'b0;
        note_data  = '0;
        mute       = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Steps n cycles after a word was applied and compares against the ideal waveform.
    task automatic hold_check(input int n, input int h, input int idx, input bit tog9,
                              output int errs);
        int exp_play;
        int exp_pwm;
        errs = 0;
        for (int e = 1; e <= n; e++) begin
            if (tog9) note_data[9] = ~note_data[9];
            step();
            exp_play = (e >= 2) ? 1 : 0;
            exp_pwm  = (e >= 2) ? (((e - 2) / h) % 2) : 0;
            if (int'(playing) != exp_play || int'(audio_pwm) != exp_pwm ||
                int'(cur_note) != (exp_play != 0 ? idx : 0))
                errs++;
        end
    endtask

    initial begin
        int errs;
        total = 0;
        bad   = 0;

        vecs[0] = '{10'b0000000100, 1'b1, 1'b0, 1911, 1, 1'b1}; // do mid
        vecs[1] = '{10'b0010000001, 1'b1, 1'b0,  568, 6, 1'b1}; // la high
        vecs[2] = '{10'b0000001010, 1'b1, 1'b0, 3404, 2, 1'b1}; // re low
        vecs[3] = '{10'b1100000011, 1'b1, 1'b0, 1012, 7, 1'b1}; // si, octave 11, bit 9 set
        vecs[4] = '{10'b0000010000, 1'b1, 1'b0, 1516, 3, 1'b1}; // mi mid
        vecs[5] = '{10'b0000001100, 1'b1, 1'b0,    0, 0, 1'b0}; // two notes
        vecs[6] = '{10'b0000000100, 1'b0, 1'b0,    0, 0, 1'b0}; // not valid
        vecs[7] = '{10'b0000000100, 1'b1, 1'b1,    0, 0, 1'b0}; // muted
        vecs[8] = '{10'b0000000000, 1'b1, 1'b0,    0, 0, 1'b0}; // rest word

        do_reset();
        step();
        chk("reset_pwm", int'(audio_pwm), 0);
        chk("reset_sd", int'(audio_sd), 0);
        chk("reset_playing", int'(playing), 0);
        chk("reset_cur_note", int'(cur_note), 0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            note_data  = vecs[i].data;
            note_valid = vecs[i].valid;
            mute       = vecs[i].mute;
            step();
            chk($sformatf("v%0d_load_playing", i), int'(playing), 0);
            chk($sformatf("v%0d_load_pwm", i), int'(audio_pwm), 0);
            step();
            chk($sformatf("v%0d_playing", i), int'(playing), int'(vecs[i].play));
            chk($sformatf("v%0d_sd", i), int'(audio_sd), int'(vecs[i].play));
            chk($sformatf("v%0d_cur_note", i), int'(cur_note), vecs[i].idx);
            if (vecs[i].play) begin
                repeat (vecs[i].half - 1) step();
                chk($sformatf("v%0d_pre_rise", i), int'(audio_pwm), 0);
                step();
                chk($sformatf("v%0d_rise", i), int'(audio_pwm), 1);
                repeat (vecs[i].half - 1) step();
                chk($sformatf("v%0d_pre_fall", i), int'(audio_pwm), 1);
                step();
                chk($sformatf("v%0d_fall", i), int'(audio_pwm), 0);
            end else begin
                repeat (20) step();
                chk($sformatf("v%0d_still_silent", i), int'(playing), 0);
                chk($sformatf("v%0d_still_pwm", i), int'(audio_pwm), 0);
            end
        end

        // Reset pulse mid-tone with mi held, then restart through S_LOAD.
        do_reset();
        note_valid = 1'b1;
        note_data  = 10'b0000010000;
        repeat (2000) step();
        chk("rst_mid_pwm_high", int'(audio_pwm), 1);
        rst_n = 1'b0;
        step();
        chk("rst_mid_pwm", int'(audio_pwm), 0);
        chk("rst_mid_sd", int'(audio_sd), 0);
        chk("rst_mid_playing", int'(playing), 0);
        chk("rst_mid_cur_note", int'(cur_note), 0);
        rst_n = 1'b1;
        step();
        chk("rst_mid_load", int'(playing), 0);
        step();
        chk("rst_mid_play", int'(playing), 1);
        chk("rst_mid_note", int'(cur_note), 3);
        repeat (1515) step();
        chk("rst_mid_pre_rise", int'(audio_pwm), 0);
        step();
        chk("rst_mid_rise", int'(audio_pwm), 1);

        // Held do, one-sample rest, then so.
        do_reset();
        note_valid = 1'b1;
        note_data  = 10'b0000000100;
        hold_check(6000, 1911, 1, 1'b0, errs);
        chk("hold_phase_errs", errs, 0);
        chk("hold_pwm_high", int'(audio_pwm), 1);
        note_data = 10'b0000000000;
        step();
        chk("rest_playing", int'(playing), 0);
        chk("rest_pwm", int'(audio_pwm), 0);
        chk("rest_cur_note", int'(cur_note), 0);
        note_data = 10'b0001000000;
        step();
        chk("so_load_playing", int'(playing), 0);
        step();
        chk("so_playing", int'(playing), 1);
        chk("so_cur_note", int'(cur_note), 5);
        repeat (1274) step();
        chk("so_pre_rise", int'(audio_pwm), 0);
        step();
        chk("so_rise", int'(audio_pwm), 1);

        // Direct note change, then mute and release.
        do_reset();
        note_valid = 1'b1;
        note_data  = 10'b0000000100;
        repeat (2500) step();
        chk("chg_pwm_high", int'(audio_pwm), 1);
        note_data = 10'b0010000000;
        step();
        chk("chg_load_playing", int'(playing), 0);
        chk("chg_load_pwm", int'(audio_pwm), 0);
        step();
        chk("chg_playing", int'(playing), 1);
        chk("chg_cur_note", int'(cur_note), 6);
        repeat (1135) step();
        chk("chg_pre_rise", int'(audio_pwm), 0);
        step();
        chk("chg_rise", int'(audio_pwm), 1);
        mute = 1'b1;
        step();
        chk("mute_playing", int'(playing), 0);
        chk("mute_pwm", int'(audio_pwm), 0);
        chk("mute_cur_note", int'(cur_note), 0);
        mute = 1'b0;
        step();
        chk("unmute_load", int'(playing), 0);
        step();
        chk("unmute_play", int'(playing), 1);

        // Bit 9 toggling every cycle must not disturb the tone.
        do_reset();
        note_valid = 1'b1;
        note_data  = 10'b0000000100;
        hold_check(8000, 1911, 1, 1'b1, errs);
        chk("bit9_phase_errs", errs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
